// File: rtl/proc_seq_ctrl.sv
// Instruction sequencer: owns the PC, fetches from a synchronous ROM and
// issues one execute strobe per instruction with pause/step/halt control.
module proc_seq_ctrl #(
  parameter int          PC_W    = 4,
  parameter logic [7:0]  HALT_OP = 8'hFF
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            pause,
  input  logic            step,
  output logic [PC_W-1:0] imem_addr,
  input  logic [7:0]      imem_data,
  output logic [7:0]      instr,
  output logic            exec_en,
  input  logic            jmp_taken,
  input  logic [PC_W-1:0] jmp_target,
  output logic            halted,
  output logic [7:0]      retire_cnt,
  output logic [2:0]      state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_PAUSED = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      instr_q, instr_d;
  logic            exec_en_q, exec_en_d;
  logic            halted_q, halted_d;
  logic [7:0]      retire_q, retire_d;
  logic            step_pend_q, step_pend_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      instr_q     <= '0;
      exec_en_q   <= 1'b0;
      halted_q    <= 1'b0;
      retire_q    <= '0;
      step_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      exec_en_q   <= exec_en_d;
      halted_q    <= halted_d;
      retire_q    <= retire_d;
      step_pend_q <= step_pend_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    halted_d    = halted_q;
    retire_d    = retire_q;
    step_pend_d = step_pend_q;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        // a pending step overrides a held pause for one instruction
        if (pause && !step_pend_q) state_d = S_PAUSED;
        else                       state_d = S_DECODE;
      end
      S_DECODE: begin
        instr_d = imem_data;
        if (imem_data == HALT_OP) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_d     = jmp_taken ? jmp_target : pc_q + 1'b1;
        retire_d = retire_q + 8'd1;
        if (step_pend_q) begin
          step_pend_d = 1'b0;
          state_d     = S_PAUSED;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_PAUSED: begin
        if (step) begin
          step_pend_d = 1'b1;
          state_d     = S_FETCH;
        end else if (!pause) begin
          state_d = S_FETCH;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    // registered strobe lines up with the EXEC cycle
    exec_en_d = (state_d == S_EXEC);
  end

  assign imem_addr  = pc_q;
  assign instr      = instr_q;
  assign exec_en    = exec_en_q;
  assign halted     = halted_q;
  assign retire_cnt = retire_q;
  assign state      = state_q;

endmodule

// File: tb/tb_proc_seq_ctrl.sv
// Directed bench for proc_seq_ctrl: vector tables for per-cycle behaviour
// plus hand sequences for wrap, branch, pause hold and async reset.
module tb_proc_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       pause = 1'b0;
  logic       step = 1'b0;
  logic [3:0] imem_addr;
  logic [7:0] imem_data = 8'h00;
  logic [7:0] instr;
  logic       exec_en;
  logic       jmp_taken = 1'b0;
  logic [3:0] jmp_target = 4'h0;
  logic       halted;
  logic [7:0] retire_cnt;
  logic [2:0] state;

  logic [7:0] rom [16];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       p;
    logic       s;
    logic [2:0] st;
    logic [3:0] pc;
    logic [7:0] ins;
    logic       ex;
    logic       hl;
    logic [7:0] rc;
  } vec_t;

  vec_t t1[$];
  vec_t t2[$];

  proc_seq_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .pause      (pause),
    .step       (step),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .instr      (instr),
    .exec_en    (exec_en),
    .jmp_taken  (jmp_taken),
    .jmp_target (jmp_target),
    .halted     (halted),
    .retire_cnt (retire_cnt),
    .state      (state)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) imem_data <= rom[imem_addr];

  function automatic vec_t mk(
    input logic p, input logic s, input logic [2:0] st,
    input logic [3:0] pc, input logic [7:0] ins,
    input logic ex, input logic hl, input logic [7:0] rc
  );
    vec_t v;
    v.p = p; v.s = s; v.st = st; v.pc = pc;
    v.ins = ins; v.ex = ex; v.hl = hl; v.rc = rc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [24:0] snap();
    return {state, imem_addr, instr, exec_en, halted, retire_cnt};
  endfunction

  task automatic do_reset();
    rstn = 1'b0;
    pause = 1'b0;
    step = 1'b0;
    jmp_taken = 1'b0;
    jmp_target = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic run_tab(input string nm, input vec_t t[$]);
    foreach (t[i]) begin
      pause = t[i].p;
      step  = t[i].s;
      @(posedge clk);
      #1;
      step = 1'b0;
      chk($sformatf("%s_row%0d", nm, i), {7'd0, snap()},
          {7'd0, t[i].st, t[i].pc, t[i].ins, t[i].ex, t[i].hl, t[i].rc});
    end
  endtask

  // advance until n exec strobes seen, then through the retiring edge
  task automatic wait_execs(input string nm, input int n, input int budget);
    int seen = 0;
    int cyc = 0;
    while (seen < n && cyc < budget) begin
      @(posedge clk);
      #1;
      if (exec_en) seen++;
      cyc++;
    end
    chk({nm, "_execs"}, seen, n);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ex_cnt;
    int cyc;
    logic pc_moved;

    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    rom[0] = 8'h11;
    rom[1] = 8'h22;
    rom[2] = 8'hFF;

    t1.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0));
    t1.push_back(mk(0, 0, 2, 0, 8'h00, 0, 0, 0));
    t1.push_back(mk(0, 0, 3, 0, 8'h11, 1, 0, 0));
    t1.push_back(mk(0, 0, 1, 1, 8'h11, 0, 0, 1));
    t1.push_back(mk(0, 0, 2, 1, 8'h11, 0, 0, 1));
    t1.push_back(mk(0, 0, 3, 1, 8'h22, 1, 0, 1));
    t1.push_back(mk(0, 0, 1, 2, 8'h22, 0, 0, 2));
    t1.push_back(mk(0, 0, 2, 2, 8'h22, 0, 0, 2));
    t1.push_back(mk(0, 0, 5, 2, 8'hFF, 0, 1, 2));
    t1.push_back(mk(0, 1, 5, 2, 8'hFF, 0, 1, 2));
    t1.push_back(mk(1, 1, 5, 2, 8'hFF, 0, 1, 2));
    t1.push_back(mk(0, 0, 5, 2, 8'hFF, 0, 1, 2));

    t2.push_back(mk(0, 0, 1, 0, 8'h00, 0, 0, 0));
    t2.push_back(mk(0, 0, 2, 0, 8'h00, 0, 0, 0));
    t2.push_back(mk(1, 0, 3, 0, 8'h01, 1, 0, 0));
    t2.push_back(mk(1, 0, 1, 1, 8'h01, 0, 0, 1));
    t2.push_back(mk(1, 0, 4, 1, 8'h01, 0, 0, 1));
    t2.push_back(mk(1, 0, 4, 1, 8'h01, 0, 0, 1));
    t2.push_back(mk(1, 1, 1, 1, 8'h01, 0, 0, 1));
    t2.push_back(mk(1, 0, 2, 1, 8'h01, 0, 0, 1));
    t2.push_back(mk(1, 0, 3, 1, 8'h02, 1, 0, 1));
    t2.push_back(mk(1, 0, 4, 2, 8'h02, 0, 0, 2));
    t2.push_back(mk(1, 0, 4, 2, 8'h02, 0, 0, 2));
    t2.push_back(mk(0, 0, 1, 2, 8'h02, 0, 0, 2));
    t2.push_back(mk(0, 0, 2, 2, 8'h02, 0, 0, 2));
    t2.push_back(mk(0, 1, 3, 2, 8'h03, 1, 0, 2));
    t2.push_back(mk(0, 0, 1, 3, 8'h03, 0, 0, 3));
    t2.push_back(mk(0, 0, 2, 3, 8'h03, 0, 0, 3));
    t2.push_back(mk(0, 0, 3, 3, 8'h04, 1, 0, 3));
    t2.push_back(mk(0, 0, 1, 4, 8'h04, 0, 0, 4));

    // halt program
    do_reset();
    #1;
    chk("reset_state", {7'd0, snap()}, 32'd0);
    run_tab("halt", t1);

    // remaining tests use a non-halting program
    for (int i = 0; i < 16; i++) rom[i] = 8'(i + 1);

    do_reset();
    run_tab("pause", t2);

    // PC and retire counter wrap
    do_reset();
    wait_execs("wrap16", 16, 200);
    chk("wrap16_pc", {28'd0, imem_addr}, 32'd0);
    chk("wrap16_rc", {24'd0, retire_cnt}, 32'd16);
    wait_execs("wrap256", 240, 2000);
    chk("wrap256_pc", {28'd0, imem_addr}, 32'd0);
    chk("wrap256_rc", {24'd0, retire_cnt}, 32'd0);

    // branch taken / not taken
    do_reset();
    jmp_taken = 1'b1;
    jmp_target = 4'hA;
    wait_execs("jmp_t", 1, 20);
    chk("jmp_taken_pc", {28'd0, imem_addr}, 32'hA);
    do_reset();
    wait_execs("jmp_nt", 1, 20);
    chk("jmp_not_pc", {28'd0, imem_addr}, 32'h1);

    // pause raised in DECODE, then held for 10 cycles
    do_reset();
    repeat (2) @(posedge clk);
    #1;
    pause = 1'b1;
    cyc = 0;
    while (state != 3'd4 && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("hold_state", {29'd0, state}, 32'd4);
    chk("hold_pc0", {28'd0, imem_addr}, 32'd1);
    chk("hold_rc0", {24'd0, retire_cnt}, 32'd1);
    ex_cnt = 0;
    pc_moved = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (exec_en) ex_cnt++;
      if (imem_addr != 4'd1) pc_moved = 1'b1;
    end
    chk("hold_execs", ex_cnt, 0);
    chk("hold_pc_moved", {31'd0, pc_moved}, 32'd0);
    chk("hold_state_end", {29'd0, state}, 32'd4);

    // async reset during EXEC of instruction 3
    do_reset();
    wait_execs("mid", 3, 40);
    cyc = 0;
    while (!exec_en && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("mid_in_exec", {29'd0, state}, 32'd3);
    #2;
    rstn = 1'b0;
    #1;
    chk("mid_async_rst", {7'd0, snap()}, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_hold", {7'd0, snap()}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    wait_execs("restart", 1, 20);
    chk("restart_pc", {28'd0, imem_addr}, 32'd1);
    chk("restart_rc", {24'd0, retire_cnt}, 32'd1);
    chk("restart_instr", {24'd0, instr}, 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
